// File: rtl/axi_llc_b_merger.sv
// Folds per-cache-line write responses back into one AXI B beat per AW burst.
// Optional error counter port err_cnt_o is enabled by AXI_LLC_B_MERGER_ERR_CNT_EN.
module axi_llc_b_merger #(
    parameter int unsigned IdWidth    = 6,
    parameter int unsigned NumEntries = 4,
    parameter int unsigned CntWidth   = (NumEntries + 1 > 1) ? $clog2(NumEntries + 1) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [IdWidth-1:0]  desc_id_i,
    input  logic [1:0]          desc_resp_i,
    input  logic                desc_last_i,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [IdWidth-1:0]  b_id_o,
    output logic [1:0]          b_resp_o,
    output logic [CntWidth-1:0] num_open_o
`ifdef AXI_LLC_B_MERGER_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt_o
`endif
);

    localparam int unsigned IdxWidth = (NumEntries > 1) ? $clog2(NumEntries) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_DECERR || b == RESP_DECERR) begin
            return RESP_DECERR;
        end else if (a == RESP_SLVERR || b == RESP_SLVERR) begin
            return RESP_SLVERR;
        end else if (a == RESP_EXOKAY && b == RESP_EXOKAY) begin
            return RESP_EXOKAY;
        end
        return RESP_OKAY;
    endfunction

    logic [NumEntries-1:0] vld_q, vld_d;
    logic [IdWidth-1:0]    id_q  [NumEntries];
    logic [IdWidth-1:0]    id_d  [NumEntries];
    logic [1:0]            acc_q [NumEntries];
    logic [1:0]            acc_d [NumEntries];

    logic                  b_valid_q, b_valid_d;
    logic [IdWidth-1:0]    b_id_q, b_id_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [CntWidth-1:0]   num_open_q, num_open_d;

    logic [NumEntries-1:0] hit_vec;
    logic                  hit;
    logic                  free_any;
    logic [IdxWidth-1:0]   hit_idx;
    logic [IdxWidth-1:0]   free_idx;
    logic [1:0]            merged_resp;
    logic                  desc_hs;

    for (genvar gi = 0; gi < NumEntries; gi++) begin : g_hit
        assign hit_vec[gi] = vld_q[gi] && (id_q[gi] == desc_id_i);
    end

    assign hit      = |hit_vec;
    assign free_any = ~&vld_q;

    // Scan downwards so the lowest matching / free index wins.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = IdxWidth'(i);
            if (!vld_q[i])  free_idx = IdxWidth'(i);
        end
    end

    assign merged_resp  = merge_resp(acc_q[hit_idx], desc_resp_i);
    assign desc_ready_o = desc_last_i ? (!b_valid_q || b_ready_i) : (hit || free_any);
    assign desc_hs      = desc_valid_i && desc_ready_o;

    always_comb begin
        vld_d      = vld_q;
        id_d       = id_q;
        acc_d      = acc_q;
        b_valid_d  = b_valid_q && !b_ready_i;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        num_open_d = '0;

        if (desc_hs) begin
            if (desc_last_i) begin
                b_valid_d = 1'b1;
                b_id_d    = desc_id_i;
                b_resp_d  = hit ? merged_resp : desc_resp_i;
                if (hit) vld_d[hit_idx] = 1'b0;
            end else if (hit) begin
                acc_d[hit_idx] = merged_resp;
            end else begin
                vld_d[free_idx] = 1'b1;
                id_d[free_idx]  = desc_id_i;
                acc_d[free_idx] = desc_resp_i;
            end
        end

        for (int i = 0; i < int'(NumEntries); i++) begin
            num_open_d = num_open_d + CntWidth'(vld_d[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q      <= '0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
            num_open_q <= '0;
            for (int i = 0; i < int'(NumEntries); i++) begin
                id_q[i]  <= '0;
                acc_q[i] <= RESP_OKAY;
            end
        end else begin
            vld_q      <= vld_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            num_open_q <= num_open_d;
        end
    end

    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = b_resp_q;
    assign num_open_o = num_open_q;

`ifdef AXI_LLC_B_MERGER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // SLVERR and DECERR both have resp[1] set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (b_valid_q && b_ready_i && b_resp_q[1] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/axi_llc_b_merger.md
Name: axi_llc_b_merger

Overview:
- Write-side response merger for the LLC.
- Upstream, each AXI AW burst is split into one descriptor per cache line; the last descriptor of a burst carries x_last=1.
- Downstream write units return one response per descriptor. This block folds those back into exactly one AXI B beat per original AW transaction, combining the responses by severity.
- Sits between the write-response path of the LLC pipeline and the slave-port B channel.

Parameters:
- IdWidth, 6, width of the AXI ID.
- NumEntries, 4, number of concurrently open multi-line bursts tracked; must be >= 1.
- CntWidth, cf_math_pkg::idx_width(NumEntries+1), width of num_open_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- desc_valid_i  in  1  per-descriptor response valid.
- desc_ready_o  out  1  per-descriptor response accepted.
- desc_id_i  in  IdWidth  AXI ID of the descriptor.
- desc_resp_i  in  2  axi_pkg resp of this descriptor.
- desc_last_i  in  1  descriptor is the last line of its burst (x_last).
- b_valid_o  out  1  merged B valid.
- b_ready_i  in  1  merged B ready.
- b_id_o  out  IdWidth  merged B ID.
- b_resp_o  out  2  merged B resp.
- num_open_o  out  CntWidth  number of occupied tracking entries.
- err_cnt_o  out  16  present only with the optional feature.

Behaviour:
- Tracking table: NumEntries entries, each holding {vld, id, acc_resp}.
- Hit: a valid entry whose id equals desc_id_i. At most one entry per ID may be valid; the bench asserts this.
- Severity merge, merge(a,b):
  - DECERR if either is DECERR;
  - else SLVERR if either is SLVERR;
  - else EXOKAY only if both are EXOKAY;
  - else OKAY.
- Handshake on desc_valid_i && desc_ready_o:
  - Hit, last=0: entry.acc_resp <= merge(acc_resp, desc_resp_i).
  - Hit, last=1: entry freed (vld<=0); the B register loads id and merge(acc_resp, desc_resp_i).
  - Miss, last=0: the lowest-index free entry is allocated with {1, desc_id_i, desc_resp_i}.
  - Miss, last=1 (single-line burst): the B register loads desc_id_i and desc_resp_i directly; no entry is touched.
- desc_ready_o:
  - When desc_last_i=1: desc_ready_o = !b_valid_o || b_ready_i.
  - When desc_last_i=0: desc_ready_o = hit || any free entry.
  - desc_ready_o may depend on desc_valid_i and the desc_* payload; it never depends combinationally on b_valid_o being dropped in the same cycle.
- B output register:
  - b_valid_o is registered: it rises 1 cycle after the last-descriptor handshake.
  - b_id_o and b_resp_o are stable while b_valid_o && !b_ready_i.
  - A new load in the same cycle as b_ready_i is allowed, giving full throughput of 1 B per cycle.
  - When no load occurs and b_ready_i=1, b_valid_o <= 0.
- num_open_o: popcount of vld, registered.
- Table full (all vld) with a miss, last=0 descriptor: desc_ready_o=0 until an entry frees. Last descriptors and hits still proceed.
- Simultaneous free and allocate in one cycle cannot occur, since there is one input per cycle.
- Reset (any cycle, including mid-burst): all vld=0, b_valid_o=0, b_id_o=0, b_resp_o=OKAY, num_open_o=0. Partial bursts are discarded.
- Width rules: resp is 2 bits with encodings per axi_pkg (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3); ID compare is full IdWidth.

Optional Feature:
- Macro: AXI_LLC_B_MERGER_ERR_CNT_EN.
- When defined: port err_cnt_o [15:0] exists. It increments by 1 on each B handshake (b_valid_o && b_ready_i) with b_resp_o of SLVERR or DECERR, saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single-line burst: id=5, resp=OKAY, last=1 -> next cycle b_valid_o=1, b_id_o=5, b_resp_o=OKAY; num_open_o stays 0.
- Three-line burst id=2 with resps OKAY, SLVERR, OKAY(last) -> exactly one B, id=2, resp=SLVERR; num_open_o goes 1, 1, then 0 after the last.
- Interleaved bursts: id=1 and id=3 alternate, 2 lines each, with resps EXOKAY,EXOKAY for id=1 and EXOKAY,DECERR for id=3 -> two B beats: id=1 EXOKAY, id=3 DECERR, in last-arrival order.
- Backpressure: b_ready_i=0 for 4 cycles while a second last-descriptor is presented -> desc_ready_o=0 during the stall, the first B is held stable, the second B follows on the cycle after b_ready_i rises.
- Full table: NumEntries=4 with 4 open IDs and a 5th new ID, last=0 -> desc_ready_o=0 until one open burst completes; then it is allocated to the lowest freed index. Reset asserted mid-burst -> b_valid_o=0, num_open_o=0; a subsequent last-only descriptor yields its own resp unmerged.
- With AXI_LLC_B_MERGER_ERR_CNT_EN: 3 SLVERR B beats and 2 OKAY beats -> err_cnt_o=3.
